// File: rtl/msg_tx.sv
// msg_tx: frames a variable-length payload as a header beat, N data beats and a checksum tail beat.
// Latency: header one cycle after start_ack; payload beats pass straight from din to dout.
// Backpressure: ready stalls header/tail in place; in DATA, ready feeds straight back to din_ready.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   start, len, start_ack   message request, its beat count, and the one-cycle acceptance pulse
//   din, din_valid, din_ready  payload source handshake (only consumed in DATA)
//   valid, head, tail, dout, ready  link beat handshake with beat-type flags
//   msg_ip                  a message is in progress (HEAD, DATA or TAIL)
module msg_tx #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              start_ack,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              valid,
  output logic              head,
  output logic              tail,
  output logic [DATA_W-1:0] dout,
  input  logic              ready,
  output logic              msg_ip
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] csum_q;
  // Registered contents of the header/tail beat; zero in IDLE so dout idles at 0.
  logic [DATA_W-1:0] beat_q;
  logic              head_q;
  logic              tail_q;
  logic              msg_ip_q;

  logic [DATA_W-1:0] csum_d;
  logic [DATA_W-1:0] len_ext;
  logic              in_data;
  logic              pay_xfer;
  logic              accept;

  always_comb begin
    len_ext              = '0;
    len_ext[LEN_W-1:0]   = len;
  end

  assign in_data  = (state_q == DATA);
  assign pay_xfer = in_data & din_valid & ready;
  assign csum_d   = csum_q ^ din;

  // A new request is taken in IDLE, or on the tail transfer so that the next
  // header follows the tail with no idle cycle. Never taken during reset.
  assign accept = ~reset & start &
                  ((state_q == IDLE) | ((state_q == TAIL) & ready));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      csum_q   <= '0;
      beat_q   <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      msg_ip_q <= 1'b0;
    end else if (accept) begin
      state_q  <= HEAD;
      len_q    <= len;
      rem_q    <= len;
      csum_q   <= '0;
      beat_q   <= len_ext;
      head_q   <= 1'b1;
      tail_q   <= 1'b0;
      msg_ip_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        HEAD: begin
          if (ready) begin
            head_q <= 1'b0;
            if (len_q != '0) begin
              state_q <= DATA;
            end else begin
              // Empty message: tail carries the (cleared) checksum.
              state_q <= TAIL;
              tail_q  <= 1'b1;
              beat_q  <= csum_q;
            end
          end
        end
        DATA: begin
          if (pay_xfer) begin
            rem_q  <= rem_q - LEN_W'(1);
            csum_q <= csum_d;
            if (rem_q == LEN_W'(1)) begin
              state_q <= TAIL;
              tail_q  <= 1'b1;
              beat_q  <= csum_d;
            end
          end
        end
        TAIL: begin
          // Tail transfer with a pending start is handled by the accept branch.
          if (ready) begin
            state_q  <= IDLE;
            tail_q   <= 1'b0;
            msg_ip_q <= 1'b0;
            beat_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start_ack = accept;
  assign din_ready = in_data & ready;
  assign valid     = head_q | tail_q | (in_data & din_valid);
  assign head      = head_q;
  assign tail      = tail_q;
  assign dout      = in_data ? din : beat_q;
  assign msg_ip    = msg_ip_q;

endmodule

// File: tb/tb_msg_tx.sv
module tb_msg_tx;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic          start_ack;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          valid;
  logic          head;
  logic          tail;
  logic [DW-1:0] dout;
  logic          ready;
  logic          msg_ip;

  always #5 clock = ~clock;

  msg_tx #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len), .start_ack(start_ack),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .valid(valid), .head(head), .tail(tail), .dout(dout), .ready(ready),
    .msg_ip(msg_ip)
  );

  int vectors = 0;
  int errors  = 0;

  // Expected link beats: {head, tail, dout}.
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] src_q[$];       // payload words the source still has to deliver
  int            pend_len[$];    // requested messages not yet accepted
  logic [DW-1:0] pend_pay[$];    // their payload words, in order

  int ack_cnt    = 0;
  int ip_cycles  = 0;
  int dr_cycles  = 0;
  int head_cyc   = 0;
  int idle_wait  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endfunction

  // Reference model: a message is a header carrying the length, the payload
  // words in order, and a tail carrying the XOR of the payload words.
  function automatic void accept_msg();
    int            l;
    logic [DW-1:0] w;
    logic [DW-1:0] x;
    l = pend_len.pop_front();
    x = '0;
    exp_q.push_back({1'b1, 1'b0, DW'(l)});
    for (int i = 0; i < l; i++) begin
      w = pend_pay.pop_front();
      src_q.push_back(w);
      exp_q.push_back({1'b0, 1'b0, w});
      x = x ^ w;
    end
    exp_q.push_back({1'b0, 1'b1, x});
    ack_cnt++;
  endfunction

  function automatic void add_rand_msg(input int l);
    pend_len.push_back(l);
    for (int i = 0; i < l; i++) pend_pay.push_back(DW'($urandom));
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  logic [DW+1:0] prev_b;
  logic [DW+1:0] got_b;
  logic          prev_stall = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (msg_ip) ip_cycles++;
      if (din_ready) dr_cycles++;
      if (head) head_cyc++;
      if (!msg_ip && pend_len.size() > 0) idle_wait++;
      got_b = {head, tail, dout};
      if (head && tail) chk("head_tail_exclusive", {head, tail}, 2'b00);
      if (!msg_ip) chk("idle_outputs", {valid, head, tail, din_ready, dout}, '0);
      if (din_ready && (head || tail)) chk("din_ready_outside_data", din_ready, 1'b0);
      if (prev_stall) chk("stall_hold", {valid, got_b}, {1'b1, prev_b});
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", got_b);
        end else begin
          chk("beat", {msg_ip, got_b}, {1'b1, exp_q.pop_front()});
        end
      end
      prev_stall = valid && !ready && (head || tail);
      prev_b     = got_b;
    end
  end

  // One clock cycle: record handshakes of the current cycle, then drive the next.
  task automatic tick(input logic rdy, input logic dv, input logic st);
    logic          took_din;
    logic          took_start;
    logic [DW-1:0] dmy;
    @(negedge clock);
    took_din   = din_valid && din_ready;
    took_start = start_ack;
    @(posedge clock);
    #1;
    if (took_din && src_q.size() > 0) dmy = src_q.pop_front();
    if (took_start) begin
      if (pend_len.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_start_ack: got 1, expected 0");
      end else begin
        accept_msg();
      end
    end
    ready     = rdy;
    din_valid = dv && (src_q.size() > 0);
    din       = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
    start     = st && (pend_len.size() > 0);
    len       = (pend_len.size() > 0) ? LW'(pend_len[0]) : LW'($urandom);
    #2;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend_len.size() > 0 || msg_ip) && n < budget) begin
      if (rnd) tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      else     tick(1'b1, 1'b1, 1'b1);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_before;

    // Reset, with start asserted throughout: nothing may be accepted.
    reset = 1'b1; start = 1'b1; len = LW'(5); ready = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) @(posedge clock);
    #3;
    chk("reset_outputs", {msg_ip, valid, head, tail, din_ready, start_ack, dout}, '0);
    reset = 1'b0; start = 1'b0;
    tick(1'b1, 1'b1, 1'b0);

    // Three-word message, link always ready: five consecutive beats.
    pend_len.push_back(3);
    pend_pay.push_back(8'hA1); pend_pay.push_back(8'hB2); pend_pay.push_back(8'hC3);
    ip_cycles = 0;
    tick(1'b1, 1'b1, 1'b1);
    drain(1'b0, 100);
    chk("len3_msg_ip_cycles", ip_cycles, 5);

    // Empty message: header then tail, source never asked for data.
    add_rand_msg(0);
    ip_cycles = 0; dr_cycles = 0;
    tick(1'b1, 1'b1, 1'b1);
    drain(1'b0, 100);
    chk("len0_msg_ip_cycles", ip_cycles, 2);
    chk("len0_din_ready_cycles", dr_cycles, 0);

    // Header stalled three cycles, then two payload gaps.
    add_rand_msg(2);
    head_cyc = 0;
    tick(1'b1, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("gap1_valid", valid, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("gap2_valid", valid, 1'b0);
    drain(1'b0, 100);
    chk("stalled_head_cycles", head_cyc, 4);

    // Start held high across two back-to-back messages.
    add_rand_msg(1);
    add_rand_msg(2);
    ack_cnt = 0; ip_cycles = 0; idle_wait = 0;
    drain(1'b0, 100);
    chk("b2b_start_acks", ack_cnt, 2);
    chk("b2b_msg_ip_cycles", ip_cycles, 7);
    chk("b2b_idle_wait_cycles", idle_wait, 2);

    // Reset in DATA after one of three payload words.
    add_rand_msg(3);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    add_rand_msg(1);
    ack_before = ack_cnt;
    tick(1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("reset_mid_msg_ip", {msg_ip, valid, tail}, 3'b000);
    chk("reset_start_ignored", ack_cnt, ack_before);
    chk("reset_abandoned_beats", exp_q.size(), 3);
    exp_q.delete();
    src_q.delete();
    tick(1'b1, 1'b1, 1'b1);
    drain(1'b0, 100);

    // Random messages with random link stalls, source gaps and start gaps.
    for (int m = 0; m < 60; m++) begin
      add_rand_msg(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
    end
    drain(1'b1, 20000);
    chk("random_all_beats_seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
